pin_capture: RTL
================

# pin_capture

Assembles a 4-digit PIN from single-cycle keypad strobes and presents it as a `pinPac_t` packet with a one-cycle `status` strobe. It sits directly upstream of the master-PIN update stage and the PIN comparison stages, which latch `pin_out` while `status` is high. It handles the digit count, the clear and confirm keys, and an inactivity timeout.

## Interface
- `TIMEOUT_CYCLES`, default 250_000_000: idle cycles allowed during a partial entry before it is discarded (must be ≥2).
- `clk`  in  1: system clock; everything is clocked on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `enable`  in  1: level; capture is active while high.
- `key_valid`  in  1: single-cycle strobe from the debounced keypad.
- `key_code`  in  4: 0x0–0x9 is a digit, 0xE is clear (`*`), 0xF is confirm (`#`); 0xA–0xD are ignored.
- `pin_out`  out  `pinPac_t`: `{status, digit1, digit2, digit3, digit4}`, where `digit1` is the first key pressed.
- `digit_count`  out  3: number of digits currently buffered (0–4), for the display.
- `pin_error`  out  1: one-cycle pulse when confirm is pressed with fewer than 4 digits.
- `timed_out`  out  1: one-cycle pulse when a partial entry is discarded by the timeout.

## Operation
- **States:** IDLE and COLLECT.
  - IDLE → COLLECT when `enable`=1.
  - COLLECT → IDLE when `enable`=0. This aborts the entry: buffer and count are cleared and no pulse is issued.
- **Keys in IDLE:** ignored.
- **Keys in COLLECT**, one per accepted `key_valid`:
  - **Digit with count<4:** stored in position count+1; count increments.
  - **Digit with count=4:** ignored. Count, buffer and timer are unchanged.
  - **Clear (0xE):** count=0, buffer=0. No pulse.
  - **Confirm (0xF) with count=4:** the four digits are copied to `pin_out` with `status`=1; then count=0 and buffer=0.
  - **Confirm (0xF) with count<4:** `pin_error` pulses; count=0 and buffer=0. `pin_out` is unchanged.
  - **0xA–0xD:** no effect. They do not restart the timer.
- **`pin_out` digit fields:** hold their last confirmed value until the next successful confirm or reset. They are not cleared by clear, timeout or `enable`=0.
- **Timeout counter:**
  - Width is `$clog2(TIMEOUT_CYCLES)`.
  - Runs only in COLLECT with count>0.
  - Zeroed on every accepted digit, clear or confirm.
  - On reaching `TIMEOUT_CYCLES`-1: count=0, buffer=0, `timed_out` pulses, counter zeroed.
- **Simultaneous events** (priority order):
  - `enable`=0 beats any key in the same cycle: no `status`, `pin_error` or `timed_out`.
  - A key strobe beats the timeout terminal count in the same cycle: the key is processed and the counter restarts. No `timed_out`.
- **Reset** (asynchronous, any time, including mid-entry):
  - State = IDLE.
  - `pin_out` = `{0,0,0,0,0}`.
  - `digit_count`=0, `pin_error`=0, `timed_out`=0.
  - Buffer = 0, timer = 0.

## Timing
- Key strobe in cycle N → `digit_count` updated in cycle N+1.
- Confirm in cycle N → `pin_out.status`=1 and the new digits visible in N+1. `status` returns to 0 in N+2.
- `pin_error` and `timed_out` are high for exactly one cycle, the cycle after the causing event.
- Back-to-back strobes, one per cycle, are all accepted. There is no backpressure.
- Timeout: last accepted key in cycle N → `timed_out` high in cycle N+`TIMEOUT_CYCLES` (absent further keys).
- IDLE → COLLECT takes effect one cycle after `enable` rises. A key strobe in the same cycle `enable` rises is ignored.
- All outputs are registered.

## Test plan
- **Basic entry and confirm:** `enable`=1; keys 1,2,3,4 then F on consecutive cycles.
  - `digit_count` steps 1,2,3,4 then 0.
  - `pin_out`=`{1,1,2,3,4}` for one cycle, then `{0,1,2,3,4}` held.
- **Overflow, clear, and short confirm:** keys 5,6,7,8,9,F.
  - Digit 9 is ignored; `pin_out` digits = 5,6,7,8.
  - Then keys 3,E,F: `pin_error` pulses once, `pin_out` digits stay 5,6,7,8, `digit_count`=0.
- **Timeout** with `TIMEOUT_CYCLES`=8: key 7 at cycle N, then nothing.
  - `timed_out` is high exactly at N+8 and `digit_count`=0.
  - Repeat with a key at N+7: no timeout, and the counter restarts.
- **Enable abort:** keys 1,2,3; drop `enable` in the same cycle as an F strobe.
  - No `status` and no `pin_error`; `digit_count`=0.
  - Re-enable then 4,4,4,4,F → `pin_out` digits = 4,4,4,4.
- **Async reset mid-entry:** keys 9,9; assert `rst` between clock edges.
  - All outputs go to 0 immediately.
  - After release, F gives `pin_error` (count=0), not `status`.
- **Ignored codes:** keys A,B,C,D interleaved with 1,2,3,4,F.
  - Result is identical to the basic entry test.
  - A–D keys do not restart the timeout counter.

Source files
------------

// File: rtl/pin_capture.sv
// pin_capture: assembles a 4-digit PIN from single-cycle keypad strobes.
//   clk, rst        : clock, asynchronous active-high reset
//   enable          : capture active while high (falling aborts an entry)
//   key_valid       : one-cycle key strobe
//   key_code[3:0]   : 0-9 digit, E clear, F confirm, A-D ignored
//   pin_out         : {status, digit1..digit4}; status pulses on a good confirm
//   digit_count[2:0]: digits currently buffered (0-4)
//   pin_error       : pulse on confirm with fewer than 4 digits
//   timed_out       : pulse when an idle partial entry is discarded
package pin_capture_pkg;
  typedef struct packed {
    logic       status;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
  } pinPac_t;
endpackage

module pin_capture
  import pin_capture_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output pinPac_t    pin_out,
  output logic [2:0] digit_count,
  output logic       pin_error,
  output logic       timed_out
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  // Fire one count early so the registered pulse lands exactly
  // TIMEOUT_CYCLES cycles after the last accepted key.
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 2);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t state_q, state_d;

  logic [3:0][3:0] buf_q, buf_d;   // buf_q[0] holds the first digit
  logic [2:0]      count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  pinPac_t         pin_q, pin_d;
  logic            err_q, err_d;
  logic            to_q, to_d;

  logic key_digit, key_clear, key_confirm, key_accept;

  assign key_digit   = key_valid && (key_code <= 4'd9);
  assign key_clear   = key_valid && (key_code == 4'hE);
  assign key_confirm = key_valid && (key_code == 4'hF);
  // Digits past the fourth are not accepted: they neither store nor restart the timer.
  assign key_accept  = (key_digit && (count_q < 3'd4)) || key_clear || key_confirm;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable)  state_d = COLLECT;
      COLLECT: if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next-value logic
  always_comb begin
    buf_d         = buf_q;
    count_d       = count_q;
    timer_d       = timer_q;
    pin_d         = pin_q;
    pin_d.status  = 1'b0;
    err_d         = 1'b0;
    to_d          = 1'b0;
    if (state_q == COLLECT) begin
      if (!enable) begin
        buf_d   = '0;
        count_d = '0;
        timer_d = '0;
      end else if (key_accept) begin
        timer_d = '0;
        if (key_digit) begin
          buf_d[count_q[1:0]] = key_code;
          count_d             = count_q + 3'd1;
        end else begin
          if (key_confirm) begin
            if (count_q == 3'd4) begin
              pin_d = '{status: 1'b1, digit1: buf_q[0], digit2: buf_q[1],
                        digit3: buf_q[2], digit4: buf_q[3]};
            end else begin
              err_d = 1'b1;
            end
          end
          buf_d   = '0;
          count_d = '0;
        end
      end else if (count_q != 3'd0) begin
        if (timer_q == TIMER_LAST) begin
          buf_d   = '0;
          count_d = '0;
          timer_d = '0;
          to_d    = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q   <= '0;
      count_q <= '0;
      timer_q <= '0;
      pin_q   <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
      timer_q <= timer_d;
      pin_q   <= pin_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  assign pin_out     = pin_q;
  assign digit_count = count_q;
  assign pin_error   = err_q;
  assign timed_out   = to_q;

endmodule
